spi_main_param: RTL and testbench
=================================

Name: spi_main_param

Overview:
Parametrised SPI main controller, successor to the fixed 128-bit SPI main used to ship AES blocks to and from the peripheral.
- Configurable word width, number of chip selects, run-time SCLK divider and all four SPI modes (CPOL/CPHA).
- Fully synchronous to one system clock, with an explicit start/busy/done handshake.
- Sits between the AES datapath and the external SPI pins.

Parameters:
DATA_W, 128, bits per transfer (≥2); shifted MSB first.
NUM_CS, 1, number of chip-select outputs (≥1).
CS_W, 1, width of cs_sel (≥ clog2(NUM_CS), min 1).
DIV_W, 8, width of the clk_div input.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous reset, active-high.
start  in  1  request; accepted only in IDLE.
tx  in  DATA_W  word to send; latched on accept.
mode  in  2  {CPOL,CPHA}; latched on accept.
clk_div  in  DIV_W  SCLK half-period D in clk cycles; 0 treated as 1; latched on accept.
cs_sel  in  CS_W  chip-select index; latched on accept.
miso  in  1  serial data from the peripheral.
sclk  out  1  serial clock.
mosi  out  1  serial data to the peripheral.
cs_n  out  NUM_CS  active-low chip selects.
rx  out  DATA_W  received word; updated only when done pulses.
busy  out  1  high from the cycle after accept until done.
done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - state=IDLE; sclk=0, mosi=0, cs_n=all 1, rx=0, busy=0, done=0.
  - Latched config is cleared and counters are zeroed.
- IDLE:
  - sclk = latched CPOL (0 after reset); cs_n all high; mosi=0.
  - If start=1, latch tx/mode/D/cs_sel and go to SETUP next cycle.
- SETUP:
  - Lasts D cycles; busy=1; cs_n[cs_sel]=0; sclk=CPOL.
  - If CPHA=0, mosi=tx[DATA_W-1] for the whole of SETUP.
- XFER:
  - sclk toggles every D cycles, exactly 2*DATA_W toggles, ending at CPOL level.
  - CPHA=0: sample miso on each leading edge; on each trailing edge except the last, drive the next bit.
  - CPHA=1: drive the next bit on each leading edge (first edge drives the MSB); sample miso on each trailing edge.
  - Sampled bits shift into an internal register LSB-in, so the first bit received becomes rx MSB.
- HOLD:
  - Lasts D cycles; sclk=CPOL; cs_n still asserted; mosi holds its last value.
- Completion, in the cycle after HOLD ends:
  - state=IDLE; cs_n all high; busy=0; done=1 for one cycle; rx loaded from the shift register; mosi=0.
- Latency: done asserts exactly D*(2*DATA_W+2)+1 cycles after the clk edge that samples start=1.
- start while busy, or in the done cycle, is ignored.
  - start held high re-accepts on the first IDLE cycle after done, giving back-to-back transfers.
  - cs_n deasserts for at least one cycle between transfers.
- tx, mode, clk_div and cs_sel changing during a transfer have no effect.
- cs_sel ≥ NUM_CS: the transfer runs normally with no cs_n asserted, and done still pulses.
- Counters: bit counter width clog2(DATA_W)+1; divider counter width DIV_W; no wrap-around within a transfer.
- A reset mid-transfer aborts the transfer: no done pulse, rx stays 0.

Test Plan:
1. DATA_W=8, mode=0, clk_div=2, tx=0xA5, miso tied to mosi → rx=0xA5; done at cycle 37 after accept; exactly 8 rising sclk edges; cs_n low throughout.
2. Mode sweep 0–3 with clk_div=1, tx=0x3C, peripheral model returning 0xC3 → rx=0xC3 in all modes; sclk idles at CPOL; edge-to-data alignment checked per CPHA.
3. clk_div=0 vs clk_div=1 → identical waveforms; done at cycle 19.
4. start pulsed mid-transfer, and tx changed mid-transfer → ignored: a single done, and rx/mosi reflect the original tx.
5. Assert rst at the 5th sclk edge → all outputs at reset values immediately (async); no done; the next start performs a clean transfer.
6. NUM_CS=4, cs_sel=2 → only cs_n[2] toggles; cs_sel=5 (CS_W=3) → cs_n stays 4'hF and done still pulses.

Source files
------------

// File: rtl/spi_main_param_if.sv
// SPI main controller bus interface.
// Groups the request/response handshake and the external SPI pins.
//   master modport : the controller's view (takes requests and miso, drives SCLK/MOSI/CS and results)
//   slave modport  : the user/peripheral view (drives requests and miso, observes everything else)
// Signals:
//   start, tx, mode, clk_div, cs_sel : transfer request and its configuration
//   miso                             : serial data from the peripheral
//   sclk, mosi, cs_n                 : serial clock, serial data out, active-low chip selects
//   rx, busy, done                   : received word, transfer in progress, completion pulse
interface spi_main_param_if #(
    parameter int DATA_W = 128,
    parameter int NUM_CS = 1,
    parameter int CS_W   = 1,
    parameter int DIV_W  = 8
);
    logic              start;
    logic [DATA_W-1:0] tx;
    logic [1:0]        mode;
    logic [DIV_W-1:0]  clk_div;
    logic [CS_W-1:0]   cs_sel;
    logic              miso;
    logic              sclk;
    logic              mosi;
    logic [NUM_CS-1:0] cs_n;
    logic [DATA_W-1:0] rx;
    logic              busy;
    logic              done;

    modport master (
        input  start, tx, mode, clk_div, cs_sel, miso,
        output sclk, mosi, cs_n, rx, busy, done
    );

    modport slave (
        output start, tx, mode, clk_div, cs_sel, miso,
        input  sclk, mosi, cs_n, rx, busy, done
    );
endinterface

// File: rtl/spi_main_param.sv
// Parametrised SPI main controller.
// Shifts a DATA_W-bit word MSB first in any of the four CPOL/CPHA modes, with a
// run-time SCLK half-period of D system clocks (clk_div, 0 treated as 1).
// A transfer is SETUP (D cycles, CS asserted) -> XFER (2*DATA_W SCLK toggles,
// one every D cycles) -> HOLD (D cycles), followed by a one-cycle done pulse in IDLE.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous reset, active-high
//   bus : spi_main_param_if.master (request/config in, SPI pins, rx/busy/done out)
module spi_main_param #(
    parameter int DATA_W = 128,
    parameter int NUM_CS = 1,
    parameter int CS_W   = 1,
    parameter int DIV_W  = 8
) (
    input  logic clk,
    input  logic rst,
    spi_main_param_if.master bus
);

    localparam int BIT_W = $clog2(DATA_W) + 1;
    localparam logic [BIT_W-1:0] LAST_EDGE = BIT_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [DATA_W-1:0] rx_q;
    logic              cpol_q;
    logic              cpha_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_cnt;
    logic [CS_W-1:0]   cs_q;
    logic [BIT_W-1:0]  edge_cnt;
    logic              phase_q;
    logic              mosi_q;
    logic              done_q;

    logic accept;
    logic tick;
    logic last_edge;
    logic leading;

    // The done cycle is IDLE but must not accept, which guarantees a gap on cs_n
    // between back-to-back transfers.
    assign accept    = (state == IDLE) && !done_q && bus.start;
    assign tick      = (div_cnt == div_q - DIV_W'(1));
    assign last_edge = (edge_cnt == LAST_EDGE);
    // Even-numbered toggles move SCLK away from CPOL (leading), odd ones return it.
    assign leading   = ~edge_cnt[0];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: each phase ends on a divider tick, XFER only on its last toggle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   if (tick) state_next = XFER;
            XFER:    if (tick && last_edge) state_next = HOLD;
            HOLD:    if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: configuration latch, divider, toggle counter and shift registers.
    // For CPHA=0 the MSB is already on mosi during SETUP, so the transmit shifter
    // is preloaded one bit ahead; for CPHA=1 the first leading edge drives the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_q     <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            div_q    <= '0;
            div_cnt  <= '0;
            cs_q     <= '0;
            edge_cnt <= '0;
            phase_q  <= 1'b0;
            mosi_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_sh    <= bus.mode[0] ? bus.tx : (bus.tx << 1);
                        mosi_q   <= bus.mode[0] ? 1'b0 : bus.tx[DATA_W-1];
                        cpol_q   <= bus.mode[1];
                        cpha_q   <= bus.mode[0];
                        div_q    <= (bus.clk_div == '0) ? DIV_W'(1) : bus.clk_div;
                        cs_q     <= bus.cs_sel;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                        phase_q  <= 1'b0;
                    end
                end
                SETUP: begin
                    div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                end
                XFER: begin
                    if (tick) begin
                        div_cnt <= '0;
                        phase_q <= ~phase_q;
                        if (!last_edge) begin
                            edge_cnt <= edge_cnt + BIT_W'(1);
                        end
                        if (leading ^ cpha_q) begin
                            rx_sh <= {rx_sh[DATA_W-2:0], bus.miso};
                        end else if (!last_edge) begin
                            mosi_q <= tx_sh[DATA_W-1];
                            tx_sh  <= tx_sh << 1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                HOLD: begin
                    if (tick) begin
                        div_cnt <= '0;
                        done_q  <= 1'b1;
                        rx_q    <= rx_sh;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: SCLK rests at the latched CPOL outside XFER; an out-of-range
    // cs_sel matches no output, so every chip select stays high.
    always_comb begin
        bus.busy = (state != IDLE);
        bus.sclk = cpol_q ^ phase_q;
        bus.mosi = (state == IDLE) ? 1'b0 : mosi_q;
        bus.cs_n = '1;
        if (state != IDLE) begin
            for (int i = 0; i < NUM_CS; i++) begin
                if (int'(cs_q) == i) begin
                    bus.cs_n[i] = 1'b0;
                end
            end
        end
    end

    assign bus.rx   = rx_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_spi_main_param.sv
// Testbench for spi_main_param (DATA_W=8, NUM_CS=4, CS_W=3, DIV_W=8).
// A behavioural peripheral answers on miso (or loops mosi back) and records what
// it receives; a scoreboard queue holds the expected rx word of each transfer.
module tb_spi_main_param;

    logic clk = 1'b0;
    logic rst = 1'b0;

    spi_main_param_if #(.DATA_W(8), .NUM_CS(4), .CS_W(3), .DIV_W(8)) bus ();

    spi_main_param #(.DATA_W(8), .NUM_CS(4), .CS_W(3), .DIV_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] cur_tx;
    logic [1:0] cur_mode;
    logic [2:0] cur_cs;
    int         cur_d;

    // Peripheral arming (written only by the stimulus process).
    bit         loopback = 1'b0;
    logic [7:0] arm_pattern = 8'h00;
    logic [1:0] arm_mode = 2'b00;
    int         arm_cnt = 0;

    // Peripheral state (written only by the peripheral process).
    int         seen_arm = 0;
    bit         per_cpol = 1'b0;
    bit         per_cpha = 1'b0;
    bit         in_cycle = 1'b0;
    logic [7:0] per_sh = 8'h00;
    logic [7:0] per_rx = 8'h00;
    logic       per_bit = 1'b0;
    int         rise_cnt = 0;
    int         tot_edges = 0;

    assign bus.miso = loopback ? bus.mosi : per_bit;

    // Counts every done pulse, including ones that should never happen.
    always @(posedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    // Behavioural SPI peripheral: a trailing edge only counts after a leading one,
    // so the SCLK idle-level change when a new CPOL is latched is ignored.
    always @(bus.sclk or arm_cnt) begin
        if (arm_cnt != seen_arm) begin
            seen_arm  = arm_cnt;
            per_cpol  = arm_mode[1];
            per_cpha  = arm_mode[0];
            per_sh    = arm_pattern;
            per_bit   = arm_mode[0] ? 1'b0 : arm_pattern[7];
            per_rx    = 8'h00;
            in_cycle  = 1'b0;
            rise_cnt  = 0;
            tot_edges = 0;
        end else if (bus.sclk !== per_cpol && bus.sclk !== 1'bx) begin
            in_cycle = 1'b1;
            tot_edges++;
            if (bus.sclk) rise_cnt++;
            if (per_cpha) begin
                per_bit = per_sh[7];
                per_sh  = per_sh << 1;
            end else begin
                per_rx = {per_rx[6:0], bus.mosi};
            end
        end else if (in_cycle) begin
            in_cycle = 1'b0;
            tot_edges++;
            if (bus.sclk) rise_cnt++;
            if (per_cpha) begin
                per_rx = {per_rx[6:0], bus.mosi};
            end else begin
                per_sh  = per_sh << 1;
                per_bit = per_sh[7];
            end
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one request, arms the peripheral, pushes the expected rx word and
    // returns just after the accepting clock edge.
    task automatic applyStimulus(input logic [7:0] tx_v, input logic [1:0] mode_v,
                                 input logic [7:0] div_v, input logic [2:0] cs_v,
                                 input logic [7:0] pat_v, input bit loop_v, input bit hold_v);
        bus.tx      = tx_v;
        bus.mode    = mode_v;
        bus.clk_div = div_v;
        bus.cs_sel  = cs_v;
        loopback    = loop_v;
        arm_pattern = pat_v;
        arm_mode    = mode_v;
        arm_cnt++;
        cur_tx   = tx_v;
        cur_mode = mode_v;
        cur_cs   = cs_v;
        cur_d    = (div_v == 8'd0) ? 1 : int'(div_v);
        exp_q.push_back(loop_v ? tx_v : pat_v);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_v) bus.start = 1'b0;
    endtask

    // Follows one transfer cycle by cycle against a timing model, then checks
    // latency, the done cycle, rx against the scoreboard and what the peripheral saw.
    task automatic checkOutput(input string tag);
        int         cyc;
        int         wave_bad;
        int         t;
        int         b;
        logic       exp_sclk;
        logic       exp_mosi;
        logic [3:0] exp_cs;
        logic [7:0] exp_rx;
        cyc      = 0;
        wave_bad = 0;
        exp_cs   = (cur_cs < 3'd4) ? ~(4'b0001 << cur_cs) : 4'hF;
        while (cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) break;
            t = (cyc - 1 < 2 * cur_d) ? 0 : ((cyc - 1) / cur_d - 1);
            if (t > 16) t = 16;
            exp_sclk = cur_mode[1] ^ t[0];
            if (cur_mode[0] == 1'b0) begin
                b = t / 2;
                if (b > 7) b = 7;
                exp_mosi = cur_tx[7 - b];
            end else begin
                b = (t + 1) / 2;
                exp_mosi = (b == 0) ? 1'b0 : cur_tx[8 - b];
            end
            if (bus.busy !== 1'b1 || bus.sclk !== exp_sclk || bus.mosi !== exp_mosi ||
                bus.cs_n !== exp_cs) begin
                wave_bad++;
            end
        end
        checkVal({tag, "_latency"}, cyc, cur_d * 18 + 1);
        checkVal({tag, "_wave_errs"}, wave_bad, 0);
        checkVal({tag, "_done_cycle"}, {bus.busy, bus.mosi, bus.cs_n}, {1'b0, 1'b0, 4'hF});
        exp_rx = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checkVal({tag, "_rx"}, bus.rx, exp_rx);
        checkVal({tag, "_periph_rx"}, per_rx, cur_tx);
        checkVal({tag, "_rises"}, rise_cnt, 8);
        @(negedge clk);
        checkVal({tag, "_after"}, {bus.done, bus.busy, bus.sclk}, {1'b0, 1'b0, cur_mode[1]});
    endtask

    initial begin
        int d_before;
        bus.start   = 1'b0;
        bus.tx      = 8'h00;
        bus.mode    = 2'b00;
        bus.clk_div = 8'd0;
        bus.cs_sel  = 3'd0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("reset_outputs", {bus.sclk, bus.mosi, bus.busy, bus.done, bus.cs_n, bus.rx},
                 {1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 8'h00});
        rst = 1'b0;
        @(negedge clk);

        // Loopback, mode 0, D=2
        $display("[TB] loopback mode 0 clk_div 2");
        applyStimulus(8'hA5, 2'd0, 8'd2, 3'd0, 8'h00, 1'b1, 1'b0);
        checkOutput("t1");

        // All four modes, D=1, peripheral returns 0xC3
        $display("[TB] mode sweep");
        for (int m = 0; m < 4; m++) begin
            applyStimulus(8'h3C, 2'(m), 8'd1, 3'd0, 8'hC3, 1'b0, 1'b0);
            checkOutput($sformatf("t2_m%0d", m));
        end

        // clk_div 0 behaves as 1
        $display("[TB] clk_div 0 and 1");
        applyStimulus(8'h96, 2'd0, 8'd0, 3'd0, 8'h5A, 1'b0, 1'b0);
        checkOutput("t3_div0");
        applyStimulus(8'h96, 2'd0, 8'd1, 3'd0, 8'h5A, 1'b0, 1'b0);
        checkOutput("t3_div1");

        // Mid-transfer start and config changes are ignored
        $display("[TB] mid-transfer disturbance");
        d_before = done_cnt;
        applyStimulus(8'hE1, 2'd1, 8'd2, 3'd0, 8'h27, 1'b0, 1'b0);
        fork
            checkOutput("t4");
            begin
                repeat (10) @(negedge clk);
                bus.start   = 1'b1;
                bus.tx      = 8'h0F;
                bus.mode    = 2'd3;
                bus.clk_div = 8'd5;
                bus.cs_sel  = 3'd1;
                @(negedge clk);
                bus.start = 1'b0;
            end
        join
        repeat (40) @(negedge clk);
        checkVal("t4_single_done", done_cnt - d_before, 1);
        checkVal("t4_idle", bus.busy, 1'b0);

        // Asynchronous reset on the 5th SCLK edge
        $display("[TB] reset mid-transfer");
        applyStimulus(8'h69, 2'd0, 8'd2, 3'd0, 8'hB4, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (tot_edges >= 5) break;
        end
        checkVal("t5_edge5_reached", tot_edges, 5);
        rst = 1'b1;
        #1;
        checkVal("t5_async_outputs", {bus.sclk, bus.mosi, bus.busy, bus.done, bus.cs_n, bus.rx},
                 {1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 8'h00});
        d_before = done_cnt;
        void'(exp_q.pop_front());
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        checkVal("t5_no_done", done_cnt - d_before, 0);
        checkVal("t5_rx_zero", bus.rx, 8'h00);
        applyStimulus(8'h69, 2'd0, 8'd2, 3'd0, 8'hB4, 1'b0, 1'b0);
        checkOutput("t5_clean");

        // Chip-select selection, including an out-of-range index
        $display("[TB] chip selects");
        applyStimulus(8'h81, 2'd0, 8'd1, 3'd2, 8'h7E, 1'b0, 1'b0);
        checkOutput("t6_cs2");
        d_before = done_cnt;
        applyStimulus(8'h42, 2'd0, 8'd1, 3'd5, 8'h99, 1'b0, 1'b0);
        checkOutput("t6_cs5");
        checkVal("t6_cs5_done", done_cnt - d_before, 1);

        // start held high: ignored in the done cycle, re-accepted right after
        $display("[TB] back-to-back");
        applyStimulus(8'hD2, 2'd2, 8'd1, 3'd1, 8'h1B, 1'b0, 1'b1);
        checkOutput("t7_first");
        applyStimulus(8'h2D, 2'd2, 8'd1, 3'd1, 8'hE4, 1'b0, 1'b0);
        checkOutput("t7_second");
        checkVal("t7_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
